// File: rtl/sccb_write_arbiter_if.sv
// Requester-side and I2C-master-side signals of the SCCB write arbiter.
// The arbiter takes the master modport; the surrounding logic takes the slave modport.
interface sccb_write_arbiter_if #(
  parameter int NREQ = 3
);
  logic [NREQ-1:0]      req_valid;
  logic [32*NREQ-1:0]   req_data;
  logic [NREQ-1:0]      req_delay;
  logic [NREQ-1:0]      grant;
  logic [NREQ-1:0]      req_done;
  logic [NREQ-1:0]      req_err;
  logic                 busy;
  logic [31:0]          i2c_data;
  logic                 start;
  logic                 tr_end;
  logic                 i2c_nack;
  logic [7:0]           err_count;

  modport master (
    input  req_valid, req_data, req_delay, tr_end, i2c_nack,
    output grant, req_done, req_err, busy, i2c_data, start, err_count
  );

  modport slave (
    output req_valid, req_data, req_delay, tr_end, i2c_nack,
    input  grant, req_done, req_err, busy, i2c_data, start, err_count
  );
endinterface

// File: rtl/sccb_write_arbiter.sv
// Round-robin arbiter sharing one SCCB write master between NREQ requesters,
// with NACK/timeout reporting and an optional post-write settle delay.
module sccb_write_arbiter #(
  parameter int NREQ           = 3,
  parameter int TIMEOUT_CYCLES = 2500000,
  parameter int SETTLE_CYCLES  = 125000
) (
  input  logic                 clk_25M,
  input  logic                 camera_rstn,
  sccb_write_arbiter_if.master bus
);

  localparam int SELW = $clog2(NREQ);
  localparam int TW   = $clog2(TIMEOUT_CYCLES);
  localparam int SW   = $clog2(SETTLE_CYCLES);

  typedef enum logic [2:0] {
    S_IDLE, S_LOAD, S_START, S_WAIT_END, S_RELEASE, S_SETTLE, S_FINISH
  } state_e;

  state_e            state_q, state_d;
  logic [SELW-1:0]   ptr_q, ptr_d;
  logic [SELW-1:0]   sel_q, sel_d;
  logic [NREQ-1:0]   grant_q, grant_d;
  logic [31:0]       data_q, data_d;
  logic              dly_q, dly_d;
  logic              nack_q, nack_d;
  logic              to_q, to_d;
  logic              start_q, start_d;
  logic [NREQ-1:0]   done_q, done_d;
  logic [NREQ-1:0]   err_q, err_d;
  logic [7:0]        err_count_q, err_count_d;
  logic [TW-1:0]     tcnt_q, tcnt_d;
  logic [SW-1:0]     scnt_q, scnt_d;

  logic              pick_found;
  logic [SELW-1:0]   pick_idx;

  // First pending requester at or after ptr, wrapping past NREQ-1.
  always_comb begin
    int j;
    logic [SELW-1:0] idx;
    j          = 0;
    idx        = '0;
    pick_found = 1'b0;
    pick_idx   = ptr_q;
    for (int k = 0; k < NREQ; k++) begin
      j = int'(ptr_q) + k;
      if (j >= NREQ) j = j - NREQ;
      idx = SELW'(j);
      if (!pick_found && bus.req_valid[idx]) begin
        pick_found = 1'b1;
        pick_idx   = idx;
      end
    end
  end

  always_comb begin
    // NOTE: every _d takes its hold value before the case so no path can infer a latch.
    state_d     = state_q;
    ptr_d       = ptr_q;
    sel_d       = sel_q;
    grant_d     = grant_q;
    data_d      = data_q;
    dly_d       = dly_q;
    nack_d      = nack_q;
    to_d        = to_q;
    start_d     = start_q;
    done_d      = '0;
    err_d       = '0;
    err_count_d = err_count_q;
    tcnt_d      = tcnt_q;
    scnt_d      = scnt_q;

    unique case (state_q)
      S_IDLE: begin
        if (pick_found) begin
          sel_d   = pick_idx;
          state_d = S_LOAD;
        end
      end
      S_LOAD: begin
        grant_d        = '0;
        grant_d[sel_q] = 1'b1;
        data_d         = bus.req_data[32*sel_q +: 32];
        dly_d          = bus.req_delay[sel_q];
        nack_d         = 1'b0;
        to_d           = 1'b0;
        state_d        = S_START;
      end
      S_START: begin
        start_d = 1'b1;
        tcnt_d  = '0;
        state_d = S_WAIT_END;
      end
      S_WAIT_END: begin
        // A completion seen on the terminal count still wins over the timeout.
        if (bus.tr_end) begin
          start_d = 1'b0;
          nack_d  = bus.i2c_nack;
          state_d = S_RELEASE;
        end else if (tcnt_q == TW'(TIMEOUT_CYCLES - 1)) begin
          start_d = 1'b0;
          to_d    = 1'b1;
          state_d = S_FINISH;
        end else begin
          tcnt_d = tcnt_q + 1'b1;
        end
      end
      S_RELEASE: begin
        scnt_d = '0;
        if (!bus.tr_end) begin
          state_d = (dly_q && !nack_q) ? S_SETTLE : S_FINISH;
        end
      end
      S_SETTLE: begin
        if (scnt_q == SW'(SETTLE_CYCLES - 1)) begin
          state_d = S_FINISH;
        end else begin
          scnt_d = scnt_q + 1'b1;
        end
      end
      S_FINISH: begin
        if (nack_q || to_q) begin
          err_d = grant_q;
          if (err_count_q != 8'hFF) err_count_d = err_count_q + 8'd1;
        end else begin
          done_d = grant_q;
        end
        grant_d = '0;
        ptr_d   = (sel_q == SELW'(NREQ - 1)) ? '0 : sel_q + 1'b1;
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk_25M or negedge camera_rstn) begin
    if (!camera_rstn) begin
      state_q     <= S_IDLE;
      ptr_q       <= '0;
      sel_q       <= '0;
      grant_q     <= '0;
      data_q      <= '0;
      dly_q       <= 1'b0;
      nack_q      <= 1'b0;
      to_q        <= 1'b0;
      start_q     <= 1'b0;
      done_q      <= '0;
      err_q       <= '0;
      err_count_q <= '0;
      tcnt_q      <= '0;
      scnt_q      <= '0;
    end else begin
      // NOTE: non-blocking assignments make every flop sample pre-edge values, independent of statement order.
      state_q     <= state_d;
      ptr_q       <= ptr_d;
      sel_q       <= sel_d;
      grant_q     <= grant_d;
      data_q      <= data_d;
      dly_q       <= dly_d;
      nack_q      <= nack_d;
      to_q        <= to_d;
      start_q     <= start_d;
      done_q      <= done_d;
      err_q       <= err_d;
      err_count_q <= err_count_d;
      tcnt_q      <= tcnt_d;
      scnt_q      <= scnt_d;
    end
  end

  assign bus.grant     = grant_q;
  assign bus.req_done  = done_q;
  assign bus.req_err   = err_q;
  assign bus.busy      = (state_q != S_IDLE);
  assign bus.i2c_data  = data_q;
  assign bus.start     = start_q;
  assign bus.err_count = err_count_q;

endmodule

// File: tb/tb_sccb_write_arbiter.sv
// Directed bench for sccb_write_arbiter: a vector table of whole transactions
// plus hand sequences for error-counter saturation and reset during SETTLE.
module tb_sccb_write_arbiter;

  localparam int NREQ = 3;
  localparam int TO   = 64;
  localparam int ST   = 40;

  localparam logic [31:0] D0 = 32'h7830_0882;
  localparam logic [31:0] D1 = 32'h7835_0A10;
  localparam logic [31:0] D2 = 32'h4201_0203;
  localparam logic [95:0] DATA_INIT = {D2, D1, D0};

  typedef struct {
    logic [2:0]  valid;
    logic [2:0]  delay;
    int          resp;       // cycles after start before tr_end; -1 = never
    logic        nack;
    logic        drop;       // requester withdraws and scribbles data mid-transfer
    logic [2:0]  exp_grant;
    logic [31:0] exp_data;
    logic [2:0]  exp_done;
    logic [2:0]  exp_err;
    logic [7:0]  exp_cnt;
    int          exp_hi;     // cycles start stays high
    int          exp_tail;   // cycles from tr_end release to done/err
  } vec_t;

  logic clk_25M = 1'b0;
  logic camera_rstn;
  int   n_checks = 0;
  int   n_errors = 0;

  sccb_write_arbiter_if #(.NREQ(NREQ)) bus ();

  sccb_write_arbiter #(
    .NREQ(NREQ), .TIMEOUT_CYCLES(TO), .SETTLE_CYCLES(ST)
  ) dut (
    .clk_25M     (clk_25M),
    .camera_rstn (camera_rstn),
    .bus         (bus)
  );

  always #20 clk_25M = ~clk_25M;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk_25M);
    @(negedge clk_25M);
  endtask

  // Called on a negedge with the arbiter in IDLE and requests already driven.
  // Plays the I2C master and returns at the negedge where done/err is visible.
  task automatic do_txn(input int resp, input logic nack, input logic drop,
                        output int lat, output logic [2:0] g, output logic [31:0] d,
                        output int hi, output int tail,
                        output logic [2:0] dn, output logic [2:0] er);
    int n;
    lat = 0; hi = 0; tail = 0; g = '0; d = '0; dn = '0; er = '0;
    n = 0;
    do begin
      tick();
      n++;
      if (n == 1) check("pulse_width", 32'({bus.req_done, bus.req_err}), 32'd0);
    end while (!bus.start && n < 16);
    lat = n;
    if (!bus.start) begin
      check("start_seen", 32'(bus.start), 32'd1);
      return;
    end
    g = bus.grant;
    if (drop) begin
      bus.req_valid = '0;
      bus.req_data  = {3{32'hDEAD_BEEF}};
    end
    if (resp >= 0) begin
      repeat (resp) begin
        tick();
        hi++;
      end
      bus.tr_end   = 1'b1;
      bus.i2c_nack = nack;
    end
    n = 0;
    do begin
      tick();
      hi++;
      n++;
    end while (bus.start && n < TO + 8);
    d = bus.i2c_data;
    bus.tr_end   = 1'b0;
    bus.i2c_nack = 1'b0;
    n = 0;
    do begin
      tick();
      n++;
    end while (!(|bus.req_done || |bus.req_err) && n < ST + 8);
    tail = n;
    dn   = bus.req_done;
    er   = bus.req_err;
    check("busy_gap", 32'(bus.busy), 32'd0);
  endtask

  vec_t        vecs [12];
  int          lat, hi, tail, n;
  logic [2:0]  g, dn, er;
  logic [31:0] d;

  initial begin
    //          valid   delay   resp nack  drop  grant   data done    err     cnt    hi  tail
    vecs[0]  = '{3'b001, 3'b001, 30, 1'b0, 1'b0, 3'b001, D0, 3'b001, 3'b000, 8'd0, 31, ST+2};
    vecs[1]  = '{3'b111, 3'b000, 10, 1'b0, 1'b0, 3'b010, D1, 3'b010, 3'b000, 8'd0, 11, 2};
    vecs[2]  = '{3'b111, 3'b000, 10, 1'b0, 1'b0, 3'b100, D2, 3'b100, 3'b000, 8'd0, 11, 2};
    vecs[3]  = '{3'b111, 3'b000, 10, 1'b0, 1'b0, 3'b001, D0, 3'b001, 3'b000, 8'd0, 11, 2};
    vecs[4]  = '{3'b111, 3'b000, 10, 1'b0, 1'b0, 3'b010, D1, 3'b010, 3'b000, 8'd0, 11, 2};
    vecs[5]  = '{3'b010, 3'b010,  5, 1'b1, 1'b0, 3'b010, D1, 3'b000, 3'b010, 8'd1,  6, 2};
    vecs[6]  = '{3'b011, 3'b000,  4, 1'b0, 1'b0, 3'b001, D0, 3'b001, 3'b000, 8'd1,  5, 2};
    vecs[7]  = '{3'b101, 3'b000,  4, 1'b0, 1'b0, 3'b100, D2, 3'b100, 3'b000, 8'd1,  5, 2};
    vecs[8]  = '{3'b100, 3'b000, -1, 1'b0, 1'b0, 3'b100, D2, 3'b000, 3'b100, 8'd2, TO, 1};
    vecs[9]  = '{3'b001, 3'b000, TO-1, 1'b0, 1'b0, 3'b001, D0, 3'b001, 3'b000, 8'd2, TO, 2};
    vecs[10] = '{3'b010, 3'b000,  8, 1'b0, 1'b1, 3'b010, D1, 3'b010, 3'b000, 8'd2,  9, 2};
    vecs[11] = '{3'b100, 3'b000,  2, 1'b1, 1'b0, 3'b100, D2, 3'b000, 3'b100, 8'd3,  3, 2};

    bus.req_valid = '0;
    bus.req_data  = DATA_INIT;
    bus.req_delay = '0;
    bus.tr_end    = 1'b0;
    bus.i2c_nack  = 1'b0;
    camera_rstn   = 1'b0;
    repeat (3) @(negedge clk_25M);

    check("rst start",     32'(bus.start),     32'd0);
    check("rst grant",     32'(bus.grant),     32'd0);
    check("rst busy",      32'(bus.busy),      32'd0);
    check("rst done_err",  32'({bus.req_done, bus.req_err}), 32'd0);
    check("rst i2c_data",  bus.i2c_data,       32'd0);
    check("rst err_count", 32'(bus.err_count), 32'd0);
    camera_rstn = 1'b1;

    for (int i = 0; i < 12; i++) begin
      bus.req_valid = vecs[i].valid;
      bus.req_delay = vecs[i].delay;
      bus.req_data  = DATA_INIT;
      do_txn(vecs[i].resp, vecs[i].nack, vecs[i].drop, lat, g, d, hi, tail, dn, er);
      check($sformatf("v%0d latency", i),   32'(lat),  32'd3);
      check($sformatf("v%0d grant", i),     32'(g),    32'(vecs[i].exp_grant));
      check($sformatf("v%0d i2c_data", i),  d,         vecs[i].exp_data);
      check($sformatf("v%0d start_hi", i),  32'(hi),   32'(vecs[i].exp_hi));
      check($sformatf("v%0d tail", i),      32'(tail), 32'(vecs[i].exp_tail));
      check($sformatf("v%0d done", i),      32'(dn),   32'(vecs[i].exp_done));
      check($sformatf("v%0d err", i),       32'(er),   32'(vecs[i].exp_err));
      check($sformatf("v%0d err_count", i), 32'(bus.err_count), 32'(vecs[i].exp_cnt));
    end
    bus.req_data  = DATA_INIT;
    bus.req_delay = '0;

    // Error counter saturation: 3 errors so far, 251 more reach 254, two more must stick at 255.
    for (int k = 0; k < 251; k++) begin
      bus.req_valid = 3'b100;
      do_txn(-1, 1'b0, 1'b0, lat, g, d, hi, tail, dn, er);
    end
    check("sat err_count 254", 32'(bus.err_count), 32'd254);
    for (int k = 0; k < 2; k++) begin
      bus.req_valid = 3'b100;
      do_txn(-1, 1'b0, 1'b0, lat, g, d, hi, tail, dn, er);
    end
    check("sat err_count 255", 32'(bus.err_count), 32'd255);
    check("sat last err",      32'(er),            32'b100);

    // Move the pointer to 2, then reset in the middle of a settle delay.
    bus.req_valid = 3'b010;
    do_txn(2, 1'b0, 1'b0, lat, g, d, hi, tail, dn, er);
    check("pre grant", 32'(g),  32'b010);
    check("pre done",  32'(dn), 32'b010);

    bus.req_valid = 3'b101;
    bus.req_delay = 3'b111;
    n = 0;
    do begin
      tick();
      n++;
    end while (!bus.start && n < 16);
    check("settle grant", 32'(bus.grant), 32'b100);
    bus.tr_end = 1'b1;
    tick();
    bus.tr_end = 1'b0;
    repeat (5) tick();
    check("settle busy",      32'(bus.busy),     32'd1);
    check("settle no pulse",  32'({bus.req_done, bus.req_err}), 32'd0);
    camera_rstn = 1'b0;
    #1;
    check("mid rst start",     32'(bus.start),     32'd0);
    check("mid rst grant",     32'(bus.grant),     32'd0);
    check("mid rst busy",      32'(bus.busy),      32'd0);
    check("mid rst i2c_data",  bus.i2c_data,       32'd0);
    check("mid rst err_count", 32'(bus.err_count), 32'd0);
    for (int k = 0; k < 3; k++) begin
      @(negedge clk_25M);
      check("mid rst no pulse", 32'({bus.req_done, bus.req_err}), 32'd0);
    end
    bus.req_delay = '0;
    camera_rstn   = 1'b1;
    do_txn(3, 1'b0, 1'b0, lat, g, d, hi, tail, dn, er);
    check("post rst latency",   32'(lat),           32'd3);
    check("post rst grant",     32'(g),             32'b001);
    check("post rst i2c_data",  d,                  D0);
    check("post rst done",      32'(dn),            32'b001);
    check("post rst err_count", 32'(bus.err_count), 32'd0);
    bus.req_valid = '0;
    tick();

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/sccb_write_arbiter.md
Name: sccb_write_arbiter

Overview:
- Shares the single SCCB/I2C write master (32-bit frame {dev_addr, reg_addr[15:0], reg_data}, start/tr_end handshake) between several requesters.
- Typical requesters: the power-up register-table sequencer, runtime exposure/strobe control and a debug port.
- Provides round-robin arbitration, per-transaction NACK and timeout detection, and an optional post-write settle delay (e.g. 5 ms after software reset 0x3008=0x82).
- Sits between the requesters and the I2C master in the camera-config subsystem; all in the clk_25M domain.

Parameters:
- NREQ, 3, number of requesters (2..8).
- TIMEOUT_CYCLES, 2500000, max clk_25M cycles from start to tr_end (100 ms).
- SETTLE_CYCLES, 125000, post-write delay when requested (5 ms).

Ports:
- clk_25M  in  1  system clock.
- camera_rstn  in  1  asynchronous active-low reset.
- req_valid  in  NREQ  request i pending; held until done/err for i.
- req_data  in  32*NREQ  frame for requester i at [32i+31:32i].
- req_delay  in  NREQ  apply SETTLE_CYCLES after this write.
- grant  out  NREQ  one-hot owner of the current transaction.
- req_done  out  NREQ  1-cycle pulse: write acknowledged, settle elapsed.
- req_err  out  NREQ  1-cycle pulse: NACK or timeout.
- busy  out  1  high in any state except IDLE.
- i2c_data  out  32  frame to the master.
- start  out  1  master start level.
- tr_end  in  1  master transfer-complete level.
- i2c_nack  in  1  master NACK flag, valid while tr_end is high.
- err_count  out  8  saturating count of errors since reset.

Behaviour:
- Reset (asynchronous, camera_rstn=0): all outputs 0, state IDLE, round-robin pointer=0, all counters 0. Reset mid-transfer drops start immediately; no done/err is issued.
- States: IDLE, LOAD, START, WAIT_END, RELEASE, SETTLE, FINISH.
- IDLE:
  - If any req_valid is high, pick the first set bit searching from ptr upward with wrap.
  - Registered into sel; go to LOAD.
- LOAD:
  - grant[sel]<=1.
  - i2c_data<=req_data[sel].
  - dly<=req_delay[sel].
  - nack_f<=0.
  - Go to START.
- START: start<=1; timeout counter cleared; go to WAIT_END.
- WAIT_END:
  - start stays high.
  - If tr_end=1: start<=0, nack_f<=i2c_nack; go to RELEASE.
  - Otherwise, when the counter reaches TIMEOUT_CYCLES-1: start<=0, to_f<=1; go to FINISH (skip RELEASE/SETTLE).
- RELEASE: wait for tr_end=0; then go to SETTLE if dly and !nack_f, else FINISH.
- SETTLE: count SETTLE_CYCLES cycles, then go to FINISH.
- FINISH:
  - Pulse req_err[sel] if nack_f or to_f, else req_done[sel], for exactly 1 cycle.
  - err_count+1 on error, saturating at 255.
  - grant<=0; ptr<=sel+1 mod NREQ; go to IDLE.
- Latency: req_valid rise in IDLE -> start high 3 cycles later (IDLE, LOAD, START registered).
- i2c_data and grant are stable from LOAD through FINISH. Requester changes to req_data after LOAD are ignored.
- req_valid dropped mid-transaction: the transaction completes and the done/err pulse is still issued.
- A requester may keep req_valid high after its done pulse with new data for back-to-back writes. It is re-eligible next IDLE but ranks last due to pointer rotation.
- Simultaneous requests are served in round-robin order. Starvation is bounded to NREQ-1 transactions.
- Requests are only sampled in IDLE.
- Counters: timeout counter width $clog2(TIMEOUT_CYCLES); settle counter width $clog2(SETTLE_CYCLES). No wrap: each counter stops at its terminal value.
- tr_end already high on entering WAIT_END (stale) is accepted as completion; the master guarantees it is low when idle.

Test Plan:
- Single request: req_valid=001, data=0x78300882, delay=1, tr_end rises 100 cycles after start.
  -> start high 3 cycles after req, i2c_data=0x78300882, done[0] pulse 125000 cycles after tr_end falls, err_count=0.
- Contention: all three valid, no delay, tr_end response 10 cycles.
  -> grant order 001,010,100,001,…; each done pulse 1 cycle wide; busy low for exactly 1 cycle (IDLE) between transfers.
- NACK: i2c_nack=1 with tr_end, delay=1.
  -> SETTLE skipped, req_err pulse, no req_done, err_count=1.
- Timeout: TIMEOUT_CYCLES=1000 in bench, tr_end never rises.
  -> start falls exactly 1000 cycles after rising, req_err pulse, err_count increments; then 256 timeouts -> err_count stays 255.
- Requester drops req_valid during WAIT_END.
  -> transaction completes, done pulse issued, i2c_data unchanged despite req_data changing mid-transfer.
- camera_rstn asserted in SETTLE.
  -> all outputs 0 immediately, no done pulse; after release, a pending req_valid restarts from ptr=0.
